// File: rtl/if_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory, branch unit and decode.
// The master modport is the fetch stage's view; the slave modport is its environment's view.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, inst, inst_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, inst, inst_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_stage.sv
// RV64I fetch stage: PC, credit-limited imem requests, DEPTH-entry buffer to decode.
// Response to id_valid is one cycle (registered buffer); id_ready low stalls via credits.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input logic      clk,
  input logic      rst,
  if_stage_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [63:0]   pc;
  logic [63:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_inst [DEPTH];
  logic [63:0]   fifo_pc   [DEPTH];

  logic          empty;
  logic          req_fire;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic [31:0]   resp_word;
  logic [63:0]   redirect_base;
  logic [CW-1:0] inflight_after_resp;

  assign empty     = (count == '0);
  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  assign resp_drop = (drop_cnt != '0);
  assign push      = bus.imem_resp_valid & ~resp_drop & ~bus.redirect_valid;
  assign pop       = bus.id_valid & bus.id_ready;
  assign resp_word = resp_pc[2] ? bus.imem_resp_data[63:32] : bus.imem_resp_data[31:0];
  assign redirect_base       = {bus.redirect_pc[63:2], 2'b00};
  assign inflight_after_resp = inflight - CW'(bus.imem_resp_valid);

  // Credits cover both outstanding requests and buffered words, so a response always has a slot.
  assign bus.imem_req_valid = rst & ~bus.redirect_valid
                            & (({1'b0, inflight} + {1'b0, count}) < DEPTH_C);
  assign bus.imem_req_addr  = {pc[63:3], 3'b000};
  assign bus.id_valid       = rst & ~empty & ~bus.redirect_valid;
  assign bus.inst           = (rst & ~empty) ? fifo_inst[rd_ptr] : 32'd0;
  assign bus.inst_addr      = (rst & ~empty) ? fifo_pc[rd_ptr]   : 64'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      // Every request still outstanding belongs to the wrong path.
      pc       <= redirect_base;
      resp_pc  <= redirect_base;
      inflight <= inflight_after_resp;
      drop_cnt <= inflight_after_resp;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (req_fire) pc <= pc + 64'd4;
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_resp_valid);
      if (bus.imem_resp_valid && resp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (push) begin
        fifo_inst[wr_ptr] <= resp_word;
        fifo_pc[wr_ptr]   <= resp_pc;
        wr_ptr            <= wr_ptr + AW'(1);
        resp_pc           <= resp_pc + 64'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (({1'b0, inflight} + {1'b0, count}) <= DEPTH_C);
      assert (drop_cnt <= inflight);
      assert (!(bus.imem_resp_valid && inflight == '0));
      assert (!(push && !pop && count == CW'(DEPTH)));
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory model with in-order variable-latency responses,
// and a scoreboard holding the instruction stream the fetch stage should deliver.
module tb_if_stage;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    int          due;
  } rsp_t;

  exp_t        exp_q[$];
  rsp_t        mem_q[$];
  logic [63:0] pop_log[$];
  logic [63:0] model_pc;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          last_due = 0;
  int          first_valid_cyc = -1;
  int          rdy_pct, idr_pct, lat_lo, lat_hi, redir_pct;
  bit          fired;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction word stored at byte address a (word-granular).
  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [31:0] x;
    x = a[31:0] * 32'h9E37_79B1;
    return x ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  function automatic bit pick(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle of stimulus. mode 0: no redirect, 1: redirect, 2: redirect only
  // if a response and a decode handshake coincide this cycle.
  task automatic step(input bit rst_v, input int mode, input logic [63:0] rpc);
    logic [63:0] a;
    rsp_t        r;
    int          lat;
    @(negedge clk);
    rst                 = rst_v;
    bus.redirect_valid  = (mode == 1);
    bus.redirect_pc     = rpc;
    bus.imem_req_ready  = pick(rdy_pct);
    bus.id_ready        = pick(idr_pct);
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = {$urandom, $urandom};
    if (!rst_v) begin
      mem_q.delete();
      exp_q.delete();
      model_pc = RESET_PC;
      last_due = 0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    if (mode == 2) begin
      bus.id_ready = 1'b1;
      #1;
      if (bus.id_valid && bus.imem_resp_valid) bus.redirect_valid = 1'b1;
    end
    fired = rst_v && bus.redirect_valid;
    if (fired) begin
      exp_q.delete();
      model_pc = {rpc[63:2], 2'b00};
    end
    #1;
    if (fired) begin
      check("redir_req_valid", bus.imem_req_valid, 64'd0);
      check("redir_id_valid", bus.id_valid, 64'd0);
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_req_addr, {model_pc[63:3], 3'b000});
      a      = bus.imem_req_addr;
      lat    = int'($urandom_range(lat_hi, lat_lo));
      r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      r.data = {word_at(a + 64'd4), word_at(a)};
      mem_q.push_back(r);
      exp_q.push_back({model_pc, word_at(model_pc)});
      model_pc = model_pc + 64'd4;
      check("credit_limit", 64'(mem_q.size() <= DEPTH), 64'd1);
    end
  endtask

  // Monitor: compares every delivered instruction against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst) begin
      check("rst_id_valid", bus.id_valid, 64'd0);
      check("rst_req_valid", bus.imem_req_valid, 64'd0);
      check("rst_inst", bus.inst, 64'd0);
      check("rst_inst_addr", bus.inst_addr, 64'd0);
    end else if (bus.id_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_inst: got inst_addr %h, expected nothing pending (cycle %0d)",
                   bus.inst_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("inst_addr", bus.inst_addr, e.pc);
          check("inst", bus.inst, e.inst);
        end
        pop_log.push_back(bus.inst_addr);
      end
    end else if (!bus.redirect_valid) begin
      check("empty_inst", bus.inst, 64'd0);
      check("empty_inst_addr", bus.inst_addr, 64'd0);
    end
  end

  initial begin
    int rel_cyc;
    int mark;
    bit found;
    logic [63:0] rpc;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.id_ready        = 1'b0;
    rdy_pct = 100; idr_pct = 0; lat_lo = 1; lat_hi = 1; redir_pct = 0;
    model_pc = RESET_PC;

    repeat (3) step(1'b0, 0, 64'd0);

    // Startup with decode stalled: buffer fills, head stays at RESET_PC.
    step(1'b1, 0, 64'd0);
    rel_cyc = cyc;
    repeat (9) step(1'b1, 0, 64'd0);
    check("first_valid_latency", 64'(first_valid_cyc - rel_cyc), 64'd2);
    check("stall_req_valid", bus.imem_req_valid, 64'd0);
    check("stall_id_valid", bus.id_valid, 64'd1);
    check("stall_head_addr", bus.inst_addr, RESET_PC);
    check("stall_fetched", 64'(exp_q.size()), 64'(DEPTH));

    idr_pct = 100;
    repeat (20) step(1'b1, 0, 64'd0);

    // Redirect with two requests outstanding.
    lat_lo = 5; lat_hi = 5;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (mem_q.size() == 2 && mem_q[0].due > cyc + 1) begin
        step(1'b1, 1, 64'h0000_0000_8000_0102);
        found = 1'b1;
      end else begin
        step(1'b1, 0, 64'd0);
      end
    end
    check("redir_two_inflight_found", 64'(found), 64'd1);
    mark = pop_log.size();
    for (int i = 0; i < 40 && pop_log.size() == mark; i++) step(1'b1, 0, 64'd0);
    check("redir_pop_seen", 64'(pop_log.size() > mark), 64'd1);
    if (pop_log.size() > mark) check("redir_first_addr", pop_log[mark], 64'h0000_0000_8000_0100);

    // Redirect coinciding with a response and a decode handshake.
    lat_lo = 1; lat_hi = 1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b1, 2, 64'h0000_0000_8000_1006);
      found = fired;
    end
    check("redir_collision_found", 64'(found), 64'd1);
    step(1'b1, 0, 64'd0);
    check("post_redir_id_valid", bus.id_valid, 64'd0);

    // Random traffic.
    rdy_pct = 70; idr_pct = 60; lat_lo = 1; lat_hi = 5; redir_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      if (pick(redir_pct)) begin
        case ($urandom_range(2, 0))
          0:       rpc = 64'h0000_0000_8000_0000 | 64'($urandom_range(4095, 0));
          1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
          default: rpc = {$urandom, $urandom};
        endcase
        step(1'b1, 1, rpc);
      end else begin
        step(1'b1, 0, 64'd0);
      end
    end

    // Reset mid-stream with the buffer full.
    rdy_pct = 100; idr_pct = 0; lat_lo = 1; lat_hi = 1;
    repeat (12) step(1'b1, 0, 64'd0);
    check("full_req_valid", bus.imem_req_valid, 64'd0);
    check("full_id_valid", bus.id_valid, 64'd1);
    step(1'b0, 0, 64'd0);
    step(1'b1, 0, 64'd0);
    check("after_rst_id_valid", bus.id_valid, 64'd0);
    check("after_rst_inst", bus.inst, 64'd0);
    check("after_rst_inst_addr", bus.inst_addr, 64'd0);
    check("after_rst_req_valid", bus.imem_req_valid, 64'd1);
    check("after_rst_req_addr", bus.imem_req_addr, RESET_PC);
    idr_pct = 100;
    mark = pop_log.size();
    repeat (30) step(1'b1, 0, 64'd0);
    check("after_rst_progress", 64'(pop_log.size() > mark + 10), 64'd1);
    if (pop_log.size() > mark) check("after_rst_first_addr", pop_log[mark], RESET_PC);
    check("total_progress", 64'(pop_log.size() > 300), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
